// File: rtl/ram_bridge_pkg.sv
// Shared types and constants for the cache-to-DDR3 chunk bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ram_bridge_pkg;

   localparam int CHUNK_PART_DEF   = 128;
   localparam int ADDRESS_SIZE_DEF = 28;

   localparam logic [2:0] CMD_WRITE = 3'b000;
   localparam logic [2:0] CMD_READ  = 3'b001;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR      = 2'd1,
      RD_CMD  = 2'd2,
      RD_WAIT = 2'd3
   } state_t;

   // Byte address of a 16-byte chunk -> MIG column address in x16 words,
   // i.e. {1'b0, addr[N-1:4], 3'b000}. The shift right by 4 frees the top
   // bit, so the result fits the same width with a zero MSB.
   function automatic logic [63:0] app_addr_map(input logic [63:0] byte_addr);
      logic [63:0] chunk_idx;
      chunk_idx = byte_addr >> 4;
      return chunk_idx << 3;
   endfunction

endpackage

// File: rtl/ram_chunk_bridge_if.sv
// Bundles the cache-controller side and the MIG native app side of the bridge.
// Latency: n/a (wires only).
// Backpressure: app_rdy / app_wdf_rdy stall the bridge; ram_controller_ready stalls the controller.
interface ram_chunk_bridge_if
   import ram_bridge_pkg::*;
#(
   parameter int CHUNK_PART   = CHUNK_PART_DEF,
   parameter int ADDRESS_SIZE = ADDRESS_SIZE_DEF
);

   // cache controller side
   logic                      ram_controller_ready;
   logic                      ram_write_trigger;
   logic [CHUNK_PART-1:0]     ram_write_value;
   logic [ADDRESS_SIZE-1:0]   ram_write_address;
   logic                      ram_read_trigger;
   logic [ADDRESS_SIZE-1:0]   ram_read_address;
   logic [CHUNK_PART-1:0]     ram_read_value;
   logic                      ram_read_value_ready;

   // MIG native app side
   logic                      init_calib_complete;
   logic [ADDRESS_SIZE-1:0]   app_addr;
   logic [2:0]                app_cmd;
   logic                      app_en;
   logic                      app_rdy;
   logic [CHUNK_PART-1:0]     app_wdf_data;
   logic                      app_wdf_wren;
   logic                      app_wdf_end;
   logic [CHUNK_PART/8-1:0]   app_wdf_mask;
   logic                      app_wdf_rdy;
   logic [CHUNK_PART-1:0]     app_rd_data;
   logic                      app_rd_data_valid;

   logic                      bridge_error;

   // the bridge itself
   modport slave (
      output ram_controller_ready,
      input  ram_write_trigger, ram_write_value, ram_write_address,
      input  ram_read_trigger, ram_read_address,
      output ram_read_value, ram_read_value_ready,
      input  init_calib_complete,
      output app_addr, app_cmd, app_en,
      input  app_rdy,
      output app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask,
      input  app_wdf_rdy,
      input  app_rd_data, app_rd_data_valid,
      output bridge_error
   );

   // the environment: cache controller plus MIG
   modport master (
      input  ram_controller_ready,
      output ram_write_trigger, ram_write_value, ram_write_address,
      output ram_read_trigger, ram_read_address,
      input  ram_read_value, ram_read_value_ready,
      output init_calib_complete,
      input  app_addr, app_cmd, app_en,
      output app_rdy,
      input  app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask,
      output app_wdf_rdy,
      output app_rd_data, app_rd_data_valid,
      input  bridge_error
   );

endinterface

// File: rtl/ram_chunk_bridge.sv
// Serialises 128-bit chunk reads/writes from the cache controller onto a MIG DDR3 app port, one command in flight.
// Latency: read pulse 1 cycle after app_rd_data_valid; ready returns 1 cycle after the last handshake.
// Backpressure: holds app_en/app_wdf_wren until app_rdy/app_wdf_rdy; ready low while busy. Option: RAM_BRIDGE_TIMEOUT_EN.
module ram_chunk_bridge
   import ram_bridge_pkg::*;
#(
   parameter int CHUNK_PART   = CHUNK_PART_DEF,
   parameter int ADDRESS_SIZE = ADDRESS_SIZE_DEF
`ifdef RAM_BRIDGE_TIMEOUT_EN
   ,parameter int TIMEOUT_CYCLES = 1024
`endif
)(
   input logic               clk,
   input logic               rst_n,
   ram_chunk_bridge_if.slave bus
);

   state_t                    state_q, state_d;
   logic [ADDRESS_SIZE-1:0]   addr_q, addr_d;
   logic [CHUNK_PART-1:0]     wdata_q, wdata_d;
   logic                      pend_vld_q, pend_vld_d;
   logic [ADDRESS_SIZE-1:0]   pend_addr_q, pend_addr_d;
   logic                      cmd_done_q, cmd_done_d;
   logic                      wdf_done_q, wdf_done_d;
   logic [CHUNK_PART-1:0]     rd_value_q, rd_value_d;
   logic                      rd_pulse_q, rd_pulse_d;
   // Low during and for one cycle after reset so ready stays 0 while rst_n is asserted.
   logic                      run_q;

   logic                      ready_w;
   logic                      app_en_w;
   logic                      wren_w;
   logic                      cmd_hs;
   logic                      wdf_hs;

`ifdef RAM_BRIDGE_TIMEOUT_EN
   localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TMO_W-1:0]          tmo_cnt_q, tmo_cnt_d;
   logic                      tmo_expired;
   logic                      tmo_fire;
   logic                      err_q;
`endif

   assign ready_w  = run_q && (state_q == IDLE) && bus.init_calib_complete && !pend_vld_q;
   assign app_en_w = (state_q == RD_CMD) || ((state_q == WR) && !cmd_done_q);
   assign wren_w   = (state_q == WR) && !wdf_done_q;
   assign cmd_hs   = app_en_w && bus.app_rdy;
   assign wdf_hs   = wren_w && bus.app_wdf_rdy;

`ifdef RAM_BRIDGE_TIMEOUT_EN
   assign tmo_expired = (state_q == RD_WAIT) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         pend_vld_q  <= 1'b0;
         pend_addr_q <= '0;
         cmd_done_q  <= 1'b0;
         wdf_done_q  <= 1'b0;
         rd_value_q  <= '0;
         rd_pulse_q  <= 1'b0;
         run_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         pend_vld_q  <= pend_vld_d;
         pend_addr_q <= pend_addr_d;
         cmd_done_q  <= cmd_done_d;
         wdf_done_q  <= wdf_done_d;
         rd_value_q  <= rd_value_d;
         rd_pulse_q  <= rd_pulse_d;
         run_q       <= 1'b1;
      end
   end

   // Next-state logic: trigger arbitration, write handshakes, read completion.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      pend_vld_d  = pend_vld_q;
      pend_addr_d = pend_addr_q;
      cmd_done_d  = cmd_done_q;
      wdf_done_d  = wdf_done_q;
      rd_value_d  = rd_value_q;
      rd_pulse_d  = 1'b0;
`ifdef RAM_BRIDGE_TIMEOUT_EN
      tmo_fire    = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (pend_vld_q) begin
               // read that arrived together with the previous write
               addr_d     = pend_addr_q;
               pend_vld_d = 1'b0;
               state_d    = RD_CMD;
            end else if (ready_w) begin
               if (bus.ram_write_trigger) begin
                  addr_d     = bus.ram_write_address;
                  wdata_d    = bus.ram_write_value;
                  cmd_done_d = 1'b0;
                  wdf_done_d = 1'b0;
                  state_d    = WR;
                  if (bus.ram_read_trigger) begin
                     pend_vld_d  = 1'b1;
                     pend_addr_d = bus.ram_read_address;
                  end
               end else if (bus.ram_read_trigger) begin
                  addr_d  = bus.ram_read_address;
                  state_d = RD_CMD;
               end
            end
         end
         WR: begin
            // command and data beat complete independently, in any order
            if (cmd_hs) cmd_done_d = 1'b1;
            if (wdf_hs) wdf_done_d = 1'b1;
            if ((cmd_done_q || cmd_hs) && (wdf_done_q || wdf_hs)) state_d = IDLE;
         end
         RD_CMD: begin
            if (bus.app_rdy) state_d = RD_WAIT;
         end
         RD_WAIT: begin
            if (bus.app_rd_data_valid) begin
               rd_value_d = bus.app_rd_data;
               rd_pulse_d = 1'b1;
               state_d    = IDLE;
            end
`ifdef RAM_BRIDGE_TIMEOUT_EN
            else if (tmo_expired) begin
               rd_value_d = '0;
               rd_pulse_d = 1'b1;
               tmo_fire   = 1'b1;
               state_d    = IDLE;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef RAM_BRIDGE_TIMEOUT_EN
   // Watchdog counts cycles spent in RD_WAIT; restarts at 0 on every entry.
   always_comb begin
      tmo_cnt_d = '0;
      if ((state_q == RD_WAIT) && (state_d == RD_WAIT)) tmo_cnt_d = tmo_cnt_q + 1'b1;
   end

   // Watchdog counter and sticky error flag; only reset clears the flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         err_q     <= err_q | tmo_fire;
      end
   end

   assign bus.bridge_error = err_q;
`else
   assign bus.bridge_error = 1'b0;
`endif

   assign bus.ram_controller_ready = ready_w;
   assign bus.ram_read_value       = rd_value_q;
   assign bus.ram_read_value_ready = rd_pulse_q;
   assign bus.app_addr             = ADDRESS_SIZE'(app_addr_map(64'(addr_q)));
   assign bus.app_cmd              = (state_q == RD_CMD) ? CMD_READ : CMD_WRITE;
   assign bus.app_en               = app_en_w;
   assign bus.app_wdf_data         = wdata_q;
   assign bus.app_wdf_wren         = wren_w;
   assign bus.app_wdf_end          = wren_w;
   assign bus.app_wdf_mask         = '0;

endmodule

// File: tb/tb_ram_chunk_bridge.sv
// Directed bench for ram_chunk_bridge: drives controller and MIG sides through the interface.
// Latency: n/a.
// Backpressure: MIG readiness is scripted per step.
module tb_ram_chunk_bridge;
   import ram_bridge_pkg::*;

   localparam int CP = 128;
   localparam int AW = 28;
`ifdef RAM_BRIDGE_TIMEOUT_EN
   localparam int TMO = 32;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ram_chunk_bridge_if #(.CHUNK_PART(CP), .ADDRESS_SIZE(AW)) bus ();

   ram_chunk_bridge #(
      .CHUNK_PART(CP),
      .ADDRESS_SIZE(AW)
`ifdef RAM_BRIDGE_TIMEOUT_EN
      ,.TIMEOUT_CYCLES(TMO)
`endif
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int tests = 0;
   int fails = 0;

   // MIG-side monitor: logs accepted commands, write beats and read pulses
   logic [2:0]    log_cmd  [$];
   logic [AW-1:0] log_addr [$];
   int            n_wdf   = 0;
   int            n_pulse = 0;
   logic [CP-1:0] wdf_seen = '0;

   always @(posedge clk) begin
      if (bus.app_en && bus.app_rdy) begin
         log_cmd.push_back(bus.app_cmd);
         log_addr.push_back(bus.app_addr);
      end
      if (bus.app_wdf_wren && bus.app_wdf_rdy) begin
         n_wdf    <= n_wdf + 1;
         wdf_seen <= bus.app_wdf_data;
      end
      if (bus.ram_read_value_ready) n_pulse <= n_pulse + 1;
   end

   task automatic chk(input string tag, input logic [CP-1:0] obs, input logic [CP-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   localparam logic [CP-1:0] D1 = 128'h11111111_22222222_33333333_44444444;
   localparam logic [CP-1:0] D2 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
   localparam logic [CP-1:0] D3 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
   localparam logic [CP-1:0] D4 = 128'h01020304_05060708_090A0B0C_0D0E0F10;
   localparam logic [CP-1:0] D5 = 128'hFEDCBA98_76543210_13579BDF_2468ACE0;
   localparam logic [CP-1:0] D6 = 128'h77777777_88888888_99999999_AAAAAAAA;

   initial begin
      int  base_c;
      int  base_p;
      int  base_w;
      int  cycles;
      bit  seen;
      bit  stable;

      bus.ram_write_trigger   = 1'b0;
      bus.ram_write_value     = '0;
      bus.ram_write_address   = '0;
      bus.ram_read_trigger    = 1'b0;
      bus.ram_read_address    = '0;
      bus.init_calib_complete = 1'b1;
      bus.app_rdy             = 1'b1;
      bus.app_wdf_rdy         = 1'b1;
      bus.app_rd_data         = '0;
      bus.app_rd_data_valid   = 1'b0;

      // ---------------- reset state
      repeat (3) tick();
      chk("rst_ready", CP'(bus.ram_controller_ready), 0);
      chk("rst_app_en", CP'(bus.app_en), 0);
      chk("rst_wren", CP'(bus.app_wdf_wren), 0);
      chk("rst_app_addr", CP'(bus.app_addr), 0);
      chk("rst_rd_value", bus.ram_read_value, 0);
      chk("rst_pulse", CP'(bus.ram_read_value_ready), 0);
      chk("rst_error", CP'(bus.bridge_error), 0);
      rst_n = 1'b1;
      repeat (3) tick();
      chk("idle_ready", CP'(bus.ram_controller_ready), 1);

      // ---------------- 1: simple read of 0x10
      base_c = log_cmd.size();
      base_p = n_pulse;
      bus.ram_read_trigger = 1'b1;
      bus.ram_read_address = 28'h0000010;
      tick();
      bus.ram_read_trigger = 1'b0;
      chk("t1_app_en", CP'(bus.app_en), 1);
      chk("t1_app_cmd", CP'(bus.app_cmd), CP'(CMD_READ));
      chk("t1_app_addr", CP'(bus.app_addr), 128'h8);
      chk("t1_busy", CP'(bus.ram_controller_ready), 0);
      tick();
      chk("t1_one_cmd", CP'(log_cmd.size() - base_c), 1);
      repeat (4) tick();
      bus.app_rd_data       = D1;
      bus.app_rd_data_valid = 1'b1;
      tick();
      bus.app_rd_data       = '0;
      bus.app_rd_data_valid = 1'b0;
      chk("t1_pulse", CP'(bus.ram_read_value_ready), 1);
      chk("t1_value", bus.ram_read_value, D1);
      tick();
      chk("t1_pulse_end", CP'(bus.ram_read_value_ready), 0);
      chk("t1_value_held", bus.ram_read_value, D1);
      chk("t1_pulse_count", CP'(n_pulse - base_p), 1);
      chk("t1_ready_back", CP'(bus.ram_controller_ready), 1);

      // ---------------- 2: write 0x20, data path ready 3 cycles before command path
      base_c = log_cmd.size();
      base_w = n_wdf;
      bus.app_rdy           = 1'b0;
      bus.app_wdf_rdy       = 1'b1;
      bus.ram_write_trigger = 1'b1;
      bus.ram_write_address = 28'h0000020;
      bus.ram_write_value   = D2;
      tick();
      bus.ram_write_trigger = 1'b0;
      chk("t2_app_en", CP'(bus.app_en), 1);
      chk("t2_wren", CP'(bus.app_wdf_wren), 1);
      chk("t2_wdf_end", CP'(bus.app_wdf_end), 1);
      chk("t2_app_cmd", CP'(bus.app_cmd), CP'(CMD_WRITE));
      chk("t2_app_addr", CP'(bus.app_addr), 128'h10);
      chk("t2_wdf_data", bus.app_wdf_data, D2);
      chk("t2_mask", CP'(bus.app_wdf_mask), 0);
      tick();
      chk("t2_wren_dropped", CP'(bus.app_wdf_wren), 0);
      chk("t2_en_held", CP'(bus.app_en), 1);
      tick();
      tick();
      bus.app_rdy = 1'b1;
      tick();
      chk("t2_en_dropped", CP'(bus.app_en), 0);
      chk("t2_ready_back", CP'(bus.ram_controller_ready), 1);
      chk("t2_one_cmd", CP'(log_cmd.size() - base_c), 1);
      chk("t2_cmd_is_write", CP'(log_cmd[base_c]), CP'(CMD_WRITE));
      chk("t2_one_beat", CP'(n_wdf - base_w), 1);
      chk("t2_beat_data", wdf_seen, D2);

      // ---------------- 3: write and read triggers together
      base_c = log_cmd.size();
      base_p = n_pulse;
      bus.ram_write_trigger = 1'b1;
      bus.ram_write_address = 28'h0000020;
      bus.ram_write_value   = D4;
      bus.ram_read_trigger  = 1'b1;
      bus.ram_read_address  = 28'h0000040;
      tick();
      bus.ram_write_trigger = 1'b0;
      bus.ram_read_trigger  = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && log_cmd.size() < base_c + 2; i++) begin
         seen |= bus.ram_controller_ready;
         tick();
      end
      seen |= bus.ram_controller_ready;
      chk("t3_two_cmds", CP'(log_cmd.size() - base_c), 2);
      if (log_cmd.size() >= base_c + 2) begin
         chk("t3_first_write", CP'(log_cmd[base_c]), CP'(CMD_WRITE));
         chk("t3_second_read", CP'(log_cmd[base_c + 1]), CP'(CMD_READ));
         chk("t3_read_addr", CP'(log_addr[base_c + 1]), 128'h20);
      end
      bus.app_rd_data       = D3;
      bus.app_rd_data_valid = 1'b1;
      tick();
      bus.app_rd_data       = '0;
      bus.app_rd_data_valid = 1'b0;
      chk("t3_ready_low", CP'(seen), 0);
      chk("t3_pulse", CP'(bus.ram_read_value_ready), 1);
      chk("t3_value", bus.ram_read_value, D3);
      tick();
      chk("t3_pulse_count", CP'(n_pulse - base_p), 1);

      // ---------------- 4: calibration not done
      base_c = log_cmd.size();
      bus.init_calib_complete = 1'b0;
      tick();
      chk("t4_ready_low", CP'(bus.ram_controller_ready), 0);
      bus.ram_write_trigger = 1'b1;
      bus.ram_read_trigger  = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         seen |= bus.app_en;
      end
      bus.ram_write_trigger = 1'b0;
      bus.ram_read_trigger  = 1'b0;
      tick();
      seen |= bus.app_en;
      chk("t4_no_app_en", CP'(seen), 0);
      chk("t4_no_cmd", CP'(log_cmd.size() - base_c), 0);
      bus.init_calib_complete = 1'b1;
      tick();
      chk("t4_ready_up", CP'(bus.ram_controller_ready), 1);

      // ---------------- 5: app_rdy held low for 10 cycles
      base_c = log_cmd.size();
      bus.app_rdy          = 1'b0;
      bus.ram_read_trigger = 1'b1;
      bus.ram_read_address = 28'h0000100;
      tick();
      bus.ram_read_trigger = 1'b0;
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         stable &= (bus.app_en === 1'b1) && (bus.app_addr === 28'h80) && (bus.app_cmd === CMD_READ);
         tick();
      end
      chk("t5_cmd_stable", CP'(stable), 1);
      chk("t5_no_cmd_yet", CP'(log_cmd.size() - base_c), 0);
      bus.app_rdy = 1'b1;
      tick();
      chk("t5_one_cmd", CP'(log_cmd.size() - base_c), 1);
      chk("t5_en_dropped", CP'(bus.app_en), 0);
      bus.app_rd_data       = D5;
      bus.app_rd_data_valid = 1'b1;
      tick();
      bus.app_rd_data       = '0;
      bus.app_rd_data_valid = 1'b0;
      chk("t5_pulse", CP'(bus.ram_read_value_ready), 1);
      chk("t5_value", bus.ram_read_value, D5);
      tick();

      // ---------------- 6b: reset while waiting for read data
      base_c = log_cmd.size();
      bus.ram_read_trigger = 1'b1;
      bus.ram_read_address = 28'h0000300;
      tick();
      bus.ram_read_trigger = 1'b0;
      tick();
      chk("t6r_cmd", CP'(log_cmd.size() - base_c), 1);
      tick();
      rst_n = 1'b0;
      #1;
      chk("t6r_ready", CP'(bus.ram_controller_ready), 0);
      chk("t6r_app_en", CP'(bus.app_en), 0);
      chk("t6r_app_addr", CP'(bus.app_addr), 0);
      chk("t6r_value", bus.ram_read_value, 0);
      chk("t6r_pulse", CP'(bus.ram_read_value_ready), 0);
      chk("t6r_wren", CP'(bus.app_wdf_wren), 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      base_p = n_pulse;
      bus.app_rd_data       = D6;
      bus.app_rd_data_valid = 1'b1;
      tick();
      bus.app_rd_data       = '0;
      bus.app_rd_data_valid = 1'b0;
      chk("t6r_stale_pulse", CP'(bus.ram_read_value_ready), 0);
      chk("t6r_stale_value", bus.ram_read_value, 0);
      tick();
      chk("t6r_no_pulse", CP'(n_pulse - base_p), 0);
      chk("t6r_ready_back", CP'(bus.ram_controller_ready), 1);
      chk("t6r_error", CP'(bus.bridge_error), 0);

`ifdef RAM_BRIDGE_TIMEOUT_EN
      // ---------------- 6a: read data never returns
      base_c = log_cmd.size();
      bus.ram_read_trigger = 1'b1;
      bus.ram_read_address = 28'h0000400;
      tick();
      bus.ram_read_trigger = 1'b0;
      tick();
      chk("t6t_cmd", CP'(log_cmd.size() - base_c), 1);
      cycles = 0;
      while (bus.ram_read_value_ready !== 1'b1 && cycles < 4 * TMO) begin
         tick();
         cycles++;
      end
      chk("t6t_latency", CP'(cycles), CP'(TMO));
      chk("t6t_value", bus.ram_read_value, 0);
      chk("t6t_error", CP'(bus.bridge_error), 1);
      tick();
      chk("t6t_error_sticky", CP'(bus.bridge_error), 1);
      chk("t6t_ready_back", CP'(bus.ram_controller_ready), 1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
